// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, load extraction/extension, writeback select,
// load fault detection and a retired-instruction counter.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidM,
    input  logic             StallW,
    input  logic             FlushW,
    input  logic             RegWriteM,
    input  logic [4:0]       RdM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       Funct3M,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  ReadDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    output logic             ValidW,
    output logic [4:0]       RdW,
    output logic [XLEN-1:0]  ResultW,
    output logic             RegWriteW,
    output logic             ExcW,
    output logic [RET_W-1:0] instret
);

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } res_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic [4:0]      rd;
        res_src_e        src;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] pc4;
    } w_reg_t;

    w_reg_t           w_q, w_d;
    logic [RET_W-1:0] instret_q, instret_d;

    logic [1:0]       off;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [XLEN-1:0]  load_data;
    logic             misaligned;
    logic             illegal_f3;
    logic             exc;
    logic             retire;

    // Flush outranks stall; a stall holds every field.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_d = w_q;
        if (FlushW) begin
            w_d.valid    = 1'b0;
            w_d.regwrite = 1'b0;
        end else if (!StallW) begin
            w_d.valid    = ValidM;
            w_d.regwrite = RegWriteM;
            w_d.rd       = RdM;
            w_d.src      = res_src_e'(ResultSrcM);
            w_d.funct3   = Funct3M;
            w_d.alu      = ALUResultM;
            w_d.rdata    = ReadDataM;
            w_d.pc4      = PCPlus4M;
        end
    end

    // Load lane selection from the low address bits.
    always_comb begin
        off = w_q.alu[1:0];
        case (off)
            2'd0:    byte_sel = w_q.rdata[7:0];
            2'd1:    byte_sel = w_q.rdata[15:8];
            2'd2:    byte_sel = w_q.rdata[23:16];
            default: byte_sel = w_q.rdata[31:24];
        endcase
        half_sel = off[1] ? w_q.rdata[31:16] : w_q.rdata[15:0];
    end

    always_comb begin
        load_data  = '0;
        misaligned = 1'b0;
        illegal_f3 = 1'b0;
        case (w_q.funct3)
            F3_LB:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                load_data  = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = off[0];
            end
            F3_LHU: begin
                load_data  = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = off[0];
            end
            F3_LW: begin
                load_data  = w_q.rdata;
                misaligned = (off != 2'd0);
            end
            default: illegal_f3 = 1'b1;
        endcase
    end

    always_comb begin
        ResultW = '0;
        case (w_q.src)
            RES_ALU:  ResultW = w_q.alu;
            RES_LOAD: ResultW = load_data;
            RES_PC4:  ResultW = w_q.pc4;
            default:  ResultW = '0;
        endcase
    end

    assign exc = w_q.valid &
                 ((w_q.src == RES_RSVD) |
                  ((w_q.src == RES_LOAD) & (misaligned | illegal_f3)));

    // An instruction leaves W when the register is not held, or when it is flushed out.
    assign retire    = w_q.valid & ~exc & (~StallW | FlushW);
    assign instret_d = retire ? instret_q + RET_W'(1) : instret_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            w_q       <= '0;
            instret_q <= '0;
        end else begin
            w_q       <= w_d;
            instret_q <= instret_d;
        end
    end

    assign ValidW    = w_q.valid;
    assign RdW       = w_q.rd;
    assign ExcW      = exc;
    assign RegWriteW = w_q.valid & w_q.regwrite & (w_q.rd != 5'd0) & ~exc;
    assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver queues expected W responses,
// a negedge monitor compares them while the register file would commit.
module tb_writeback_stage;

    localparam int XLEN  = 32;
    localparam int RET_W = 4;   // small counter so wrap-around is reachable

    logic             clk = 1'b0;
    logic             rst;
    logic             ValidM, StallW, FlushW, RegWriteM;
    logic [4:0]       RdM;
    logic [1:0]       ResultSrcM;
    logic [2:0]       Funct3M;
    logic [XLEN-1:0]  ALUResultM, ReadDataM, PCPlus4M;
    logic             ValidW, RegWriteW, ExcW;
    logic [4:0]       RdW;
    logic [XLEN-1:0]  ResultW;
    logic [RET_W-1:0] instret;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(XLEN), .RET_W(RET_W)) dut (
        .clk(clk), .rst(rst),
        .ValidM(ValidM), .StallW(StallW), .FlushW(FlushW), .RegWriteM(RegWriteM),
        .RdM(RdM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .ValidW(ValidW), .RdW(RdW), .ResultW(ResultW), .RegWriteW(RegWriteW),
        .ExcW(ExcW), .instret(instret)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] result;
        logic        chk_res;
        logic        regwrite;
        logic        exc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] regs [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drive one M-stage instruction for one cycle; optionally queue its expected W response.
    task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [31:0] eres, input logic echk,
                         input logic erw, input logic eexc, input logic push);
        exp_t e;
        ValidM = 1'b1; RegWriteM = rw; RdM = rd; ResultSrcM = src; Funct3M = f3;
        ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4;
        if (push) begin
            e.rd = rd; e.result = eres; e.chk_res = echk; e.regwrite = erw; e.exc = eexc;
            exp_q.push_back(e);
        end
        step();
        ValidM = 1'b0; RegWriteM = 1'b0;
    endtask

    // Register-file model: commits on negedge like the real one.
    always @(negedge clk) begin
        if (RegWriteW === 1'b1) regs[RdW] <= ResultW;
    end

    // Monitor: compare the head of the queue every half-cycle W holds a valid instruction;
    // pop once the instruction is about to leave W.
    always @(negedge clk) begin
        if (rst === 1'b0 && ValidW === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_w: got ValidW=1 with RdW=%0d, required no instruction", RdW);
            end else begin
                mon_e = exp_q[0];
                check("RdW", {27'd0, RdW}, {27'd0, mon_e.rd});
                check("RegWriteW", {31'd0, RegWriteW}, {31'd0, mon_e.regwrite});
                check("ExcW", {31'd0, ExcW}, {31'd0, mon_e.exc});
                if (mon_e.chk_res) check("ResultW", ResultW, mon_e.result);
                if (StallW === 1'b0 || FlushW === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (regs[i]) regs[i] = '0;
        rst = 1'b1; ValidM = 0; StallW = 0; FlushW = 0; RegWriteM = 0; RdM = 0;
        ResultSrcM = 0; Funct3M = 0; ALUResultM = 0; ReadDataM = 0; PCPlus4M = 0;

        // Reset held two clocks, then idle.
        step(); step();
        rst = 1'b0;
        check("rst_ValidW", {31'd0, ValidW}, 32'd0);
        check("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("rst_ExcW", {31'd0, ExcW}, 32'd0);
        check("rst_ResultW", ResultW, 32'd0);
        check("rst_instret", {28'd0, instret}, 32'd0);

        // ALU op to x5.
        issue(1, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 32'h1234, 1, 1, 0, 1);
        @(negedge clk); #1;
        check("x5_after_negedge", regs[5], 32'h1234);
        step();
        check("instret_alu", {28'd0, instret}, 32'd1);

        // Load extraction from word 0x80FF7F01.
        issue(1, 5'd6, 2'b01, 3'b000, 32'h203, 32'h80FF7F01, 0, 32'hFFFFFF80, 1, 1, 0, 1);
        issue(1, 5'd7, 2'b01, 3'b100, 32'h201, 32'h80FF7F01, 0, 32'h0000007F, 1, 1, 0, 1);
        issue(1, 5'd8, 2'b01, 3'b001, 32'h202, 32'h80FF7F01, 0, 32'hFFFF80FF, 1, 1, 0, 1);
        issue(1, 5'd9, 2'b01, 3'b101, 32'h200, 32'h80FF7F01, 0, 32'h00007F01, 1, 1, 0, 1);
        step();
        check("instret_loads", {28'd0, instret}, 32'd5);
        check("x8_lh", regs[8], 32'hFFFF80FF);

        // Faulting loads and reserved ResultSrc: no write, no retirement.
        issue(1, 5'd10, 2'b01, 3'b010, 32'h102, 32'h11223344, 0, 0, 0, 0, 1, 1);
        issue(1, 5'd11, 2'b01, 3'b001, 32'h101, 32'h11223344, 0, 0, 0, 0, 1, 1);
        issue(1, 5'd12, 2'b01, 3'b011, 32'h100, 32'h11223344, 0, 0, 0, 0, 1, 1);
        issue(1, 5'd13, 2'b11, 3'b000, 32'h100, 32'h11223344, 0, 32'h0, 1, 0, 1, 1);
        step();
        check("instret_exc", {28'd0, instret}, 32'd5);
        check("x10_untouched", regs[10], 32'h0);

        // Write to x0 is suppressed; a non-writing instruction still retires.
        issue(1, 5'd0, 2'b00, 3'b000, 32'hDEAD, 0, 0, 32'hDEAD, 1, 0, 0, 1);
        issue(0, 5'd3, 2'b00, 3'b000, 32'hBEEF, 0, 0, 32'hBEEF, 1, 0, 0, 1);
        step();
        check("instret_x0_store", {28'd0, instret}, 32'd7);

        // JAL held by a three-cycle stall.
        issue(1, 5'd1, 2'b10, 3'b000, 32'h0, 0, 32'h44, 32'h44, 1, 1, 0, 1);
        StallW = 1'b1;
        step(); step(); step();
        check("instret_during_stall", {28'd0, instret}, 32'd7);
        StallW = 1'b0;
        step();
        check("instret_after_stall", {28'd0, instret}, 32'd8);
        check("x1_jal", regs[1], 32'h44);

        // Flush together with stall: W cleared, entering instruction killed.
        issue(1, 5'd14, 2'b00, 3'b000, 32'h55, 0, 0, 32'h55, 1, 1, 0, 1);
        StallW = 1'b1; FlushW = 1'b1;
        issue(1, 5'd15, 2'b00, 3'b000, 32'h66, 0, 0, 0, 0, 0, 0, 0);
        check("flush_ValidW", {31'd0, ValidW}, 32'd0);
        check("flush_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("instret_flush", {28'd0, instret}, 32'd9);
        StallW = 1'b0; FlushW = 1'b0;
        step();
        check("x15_killed", regs[15], 32'h0);

        // Counter wraps modulo 2^RET_W.
        for (int i = 0; i < 6; i++)
            issue(1, 5'(16 + i), 2'b00, 3'b000, 32'h100 + i, 0, 0, 32'h100 + i, 1, 1, 0, 1);
        step();
        check("instret_max", {28'd0, instret}, 32'd15);
        issue(1, 5'd22, 2'b00, 3'b000, 32'h200, 0, 0, 32'h200, 1, 1, 0, 1);
        step();
        check("instret_wrap", {28'd0, instret}, 32'd0);

        // Reset during a stall wins; no write in the following cycle.
        issue(1, 5'd23, 2'b00, 3'b000, 32'h300, 0, 0, 32'h300, 1, 1, 0, 1);
        step();
        check("instret_pre_reset", {28'd0, instret}, 32'd1);
        issue(1, 5'd24, 2'b00, 3'b000, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        StallW = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; StallW = 1'b0;
        check("rst_stall_ValidW", {31'd0, ValidW}, 32'd0);
        check("rst_stall_RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("rst_stall_instret", {28'd0, instret}, 32'd0);
        step(); step();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
